gal_sop_fuse_loader: RTL
========================

Name: gal_sop_fuse_loader

Overview:
- Runtime counterpart of the GAL_SOP techmap, which writes a compile-time TABLE. This block loads the same TABLE encoding as a serial fuse stream and evaluates it.
- Fuses arrive LSB-first over a valid/ready handshake and are held in a fuse register. Once a complete, correctly framed stream has loaded, the block evaluates the sum-of-products with a registered output.
- Used in emulation/bring-up fabric to check fitted GAL_SOP cells against hardware.

Parameters:
- WIDTH, 4, number of SOP inputs (>=1).
- DEPTH, 2, number of product terms (>=1).
- Derived constant NFUSE = 2*WIDTH*DEPTH, the fuse count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fuse_valid  in  1  fuse bit offered.
- fuse_ready  out  1  block accepts a fuse bit this cycle.
- fuse_bit  in  1  fuse value, TABLE bit k sent in order k=0..NFUSE-1.
- fuse_last  in  1  marks the final fuse of the stream.
- a  in  WIDTH  SOP inputs.
- y  out  1  registered SOP result.
- loaded  out  1  a valid table is held.
- err  out  1  sticky framing error.

Behaviour:
- Reset values (asynchronous): state=IDLE, fuse register all 0, count=0, y=0, loaded=0, err=0.
- Encoding, identical to GAL_SOP/$sop: for term t and input i, pair index p = t*WIDTH+i.
  - TABLE[2p] set: term requires a[i]=0.
  - TABLE[2p+1] set: term requires a[i]=1.
  - Pair 00: don't care. Pair 11: term can never be true.
- Transfer: a fuse is accepted on a cycle where fuse_valid && fuse_ready.
- States:
  - IDLE: fuse_ready=1. The first accepted bit clears loaded, clears the fuse register, stores the bit at index 0, sets count=1 and moves to LOAD. If that bit also has fuse_last, apply the LOAD last-fuse rule with count=1.
  - LOAD: fuse_ready=1. Each accepted bit is stored at index count, then count increments.
    - fuse_last on the bit that completes NFUSE: loaded=1, go to RUN.
    - fuse_last earlier, or the NFUSE-th bit without fuse_last: err=1, loaded=0, go to IDLE.
  - RUN: fuse_ready=1. An accepted bit restarts the load exactly as in IDLE, which drops loaded immediately.
- Evaluation:
  - y <= loaded ? OR over t of (AND over i of literal-match) : 0.
  - Latency is 1 cycle from a to y.
  - The cycle that sets loaded does not evaluate the new table yet; y reflects it starting the following cycle.
- Count width is clog2(NFUSE+1). Count never exceeds NFUSE, and there is no wrap.
- err is cleared only by rst. Subsequent loads still proceed while err=1.
- Reset asserted mid-load discards the partial table and loaded stays 0.

Optional Feature:
- GAL_SOP_READBACK_EN, when defined:
  - Adds ports rb_req (in, 1), rb_bit (out, 1) and rb_valid (out, 1).
  - rb_req in RUN streams the fuse register out, index 0 first, one bit per cycle with rb_valid=1 for NFUSE cycles.
  - Fuse input is stalled during readback (fuse_ready=0).
  - rb_req is ignored outside RUN.
- Undefined: none of these ports exist, and fuse_ready follows the rules above.

Decomposition:
- Package gal_sop_pkg:
  - State enum {IDLE, LOAD, RUN}.
  - Function nfuse(width, depth).
  - Literal-code constants LIT_DC=2'b00, LIT_NEG=2'b01, LIT_POS=2'b10, LIT_NEVER=2'b11.
- One sub-module gal_sop_eval: a purely combinational evaluator with parameters WIDTH/DEPTH and inputs table and a. It is also reusable by the verification model.

Test Plan:
- WIDTH=1, DEPTH=1, stream 1,0 (last on 2nd) -> loaded=1. Then a=0 gives y=1 next cycle and a=1 gives y=0 (NOT behaviour).
- WIDTH=1, DEPTH=1, stream 0,1 -> a=1 gives y=1 and a=0 gives y=0 (BUF behaviour).
- WIDTH=4, DEPTH=2, table term0=a0&~a1, term1=a3:
  - a=4'b0001 -> y=1
  - a=4'b0011 -> y=0
  - a=4'b1000 -> y=1
  - a=4'b0000 -> y=0
- fuse_last on 5th of 16 fuses -> err=1, loaded=0, y=0. A following correct 16-fuse load gives loaded=1 while err stays 1.
- Pair 11 in every term -> y=0 for all 16 values of a. Hold fuse_valid low for random cycles mid-load -> the result is identical.
- rst asserted mid-load (count=7) -> count=0, loaded=0, y=0 asynchronously. With GAL_SOP_READBACK_EN, a pulsed rb_req returns the loaded bits in order over 16 rb_valid cycles.

Source files
------------

// File: rtl/gal_sop_pkg.sv
// Shared types and constants for the GAL_SOP fuse loader and its evaluator.
// Literal codes are {TABLE[2p+1], TABLE[2p]} for pair index p = t*WIDTH+i.
package gal_sop_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [1:0] LIT_DC    = 2'b00;
  localparam logic [1:0] LIT_NEG   = 2'b01;
  localparam logic [1:0] LIT_POS   = 2'b10;
  localparam logic [1:0] LIT_NEVER = 2'b11;

  function automatic int nfuse(input int width, input int depth);
    return 2 * width * depth;
  endfunction

endpackage

// File: rtl/gal_sop_eval.sv
// Combinational sum-of-products evaluator over a GAL_SOP TABLE encoding.
module gal_sop_eval
  import gal_sop_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic [2*WIDTH*DEPTH-1:0] fuse_table,
  input  logic [WIDTH-1:0]         a,
  output logic                     sop
);

  logic term;

  always_comb begin
    sop  = 1'b0;
    term = 1'b1;
    for (int t = 0; t < DEPTH; t++) begin
      term = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
        case (fuse_table[2*(t*WIDTH+i) +: 2])
          LIT_NEG:   if (a[i])  term = 1'b0;
          LIT_POS:   if (!a[i]) term = 1'b0;
          LIT_NEVER: term = 1'b0;
          default:   ;
        endcase
      end
      sop = sop | term;
    end
  end

endmodule

// File: rtl/gal_sop_fuse_loader.sv
// Serial GAL_SOP fuse loader with registered SOP evaluation.
// Optional readback of the fuse register when GAL_SOP_READBACK_EN is defined.
//
// state | meaning
// IDLE  | no stream in progress; first accepted fuse starts a load
// LOAD  | collecting fuses at index count
// RUN   | valid table held; a new fuse restarts the load
module gal_sop_fuse_loader
  import gal_sop_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fuse_valid,
  output logic             fuse_ready,
  input  logic             fuse_bit,
  input  logic             fuse_last,
  input  logic [WIDTH-1:0] a,
`ifdef GAL_SOP_READBACK_EN
  input  logic             rb_req,
  output logic             rb_bit,
  output logic             rb_valid,
`endif
  output logic             y,
  output logic             loaded,
  output logic             err
);

  localparam int NFUSE = nfuse(WIDTH, DEPTH);
  localparam int CW    = $clog2(NFUSE + 1);
  localparam int IW    = $clog2(NFUSE);
  localparam logic [CW-1:0] FULL = CW'(NFUSE);

  state_t           state, state_d;
  logic [NFUSE-1:0] fuse_q, fuse_d;
  logic [CW-1:0]    count, count_d;
  logic [CW-1:0]    idx, cnt_next;
  logic             loaded_d, err_d;
  logic             accept, sop;

`ifdef GAL_SOP_READBACK_EN
  logic [NFUSE-1:0] rb_shift;
  logic [CW-1:0]    rb_left;
  logic             rb_busy, rb_start;

  assign rb_busy    = (rb_left != '0);
  assign rb_start   = !rb_busy && (state == RUN) && rb_req;
  assign rb_valid   = rb_busy;
  assign rb_bit     = rb_shift[0];
  // The request cycle itself also stalls, so a fuse cannot race the snapshot.
  assign fuse_ready = !(rb_busy || ((state == RUN) && rb_req));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_shift <= '0;
      rb_left  <= '0;
    end else if (rb_start) begin
      rb_shift <= fuse_q;
      rb_left  <= FULL;
    end else if (rb_busy) begin
      rb_shift <= rb_shift >> 1;
      rb_left  <= rb_left - CW'(1);
    end
  end
`else
  assign fuse_ready = 1'b1;
`endif

  assign accept = fuse_valid && fuse_ready;

  always_comb begin
    state_d  = state;
    fuse_d   = fuse_q;
    count_d  = count;
    loaded_d = loaded;
    err_d    = err;
    idx      = (state == LOAD) ? count : '0;
    cnt_next = idx + CW'(1);
    if (accept) begin
      // Outside LOAD the first fuse wipes the old table and drops loaded at once.
      if (state != LOAD) fuse_d = '0;
      fuse_d[idx[IW-1:0]] = fuse_bit;
      count_d  = cnt_next;
      loaded_d = 1'b0;
      state_d  = LOAD;
      if (fuse_last && (cnt_next == FULL)) begin
        loaded_d = 1'b1;
        state_d  = RUN;
      end else if (fuse_last || (cnt_next == FULL)) begin
        err_d   = 1'b1;
        count_d = '0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      fuse_q <= '0;
      count  <= '0;
      loaded <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_d;
      fuse_q <= fuse_d;
      count  <= count_d;
      loaded <= loaded_d;
      err    <= err_d;
    end
  end

  gal_sop_eval #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_eval (
    .fuse_table (fuse_q),
    .a          (a),
    .sop        (sop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) y <= 1'b0;
    else     y <= loaded ? sop : 1'b0;
  end

endmodule
